// File: rtl/uart_tx_axis.sv
// rtl/uart_tx_axis.sv - AXI-Stream byte in, UART start/data/stop frame out on txd
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);
  localparam int BW = (DATA_WIDTH > 8) ? 4 : 3;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity_bit;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic [15:0]           period;
  logic [15:0]           timer;
  logic                  bit_done;

  assign bit_done = (timer == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      txd           <= 1'b1;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      shreg         <= '0;
      bit_idx       <= '0;
      period        <= 16'd1;
      timer         <= 16'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd           <= 1'b1;
          busy          <= 1'b0;
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            // The handshake edge already drives the start bit, so the timer holds P-1 more cycles.
            shreg         <= s_axis_tdata;
            bit_idx       <= '0;
            period        <= (prescale == 16'd0) ? 16'd1 : prescale;
            timer         <= (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
            txd           <= 1'b0;
            state         <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= ^s_axis_tdata;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            timer <= period - 16'd1;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= period - 16'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              txd   <= parity_bit;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            timer <= period - 16'd1;
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            timer <= timer - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state         <= IDLE;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_axis.sv
// tb/tb_uart_tx_axis.sv - scoreboard bench for uart_tx_axis with a frame-level reference model
module tb_uart_tx_axis;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         txd;
  logic         busy;
  logic [15:0]  prescale = 16'd4;

  uart_tx_axis #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .txd(txd), .busy(busy), .prescale(prescale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           p;
    bit           b2b;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_active = 1'b0;
  bit    b2b_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line level of frame bit k: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic exp_bit(input logic [W-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  initial begin : monitor
    item_t      e;
    int         idle;
    int         wait_n;
    int         bad;
    bit         aborted;
    logic [2:0] got;
    logic [2:0] want;
    logic [2:0] first_bad;
    idle = 0;
    forever begin
      wait_n = 0;
      forever begin
        @(negedge clk);
        if (busy === 1'b1 && rst === 1'b0) break;
        if (s_axis_tready === 1'b1) idle++;
        wait_n++;
        if (sb.size() != 0 && wait_n > 5000) begin
          check("frame_start_timeout", 32'd0, 32'd1);
          sb.delete(0);
          wait_n = 0;
        end
      end
      mon_active = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_frame", 32'd0, 32'd1);
        wait_n = 0;
        while (busy === 1'b1 && wait_n < 20000) begin
          @(negedge clk);
          wait_n++;
        end
        idle = 0;
      end else begin
        e = sb.pop_front();
        if (e.b2b) check($sformatf("b2b_gap_%02h", e.data), idle, 1);
        aborted = 1'b0;
        for (int k = 0; k < NB && !aborted; k++) begin
          bad = 0;
          want = {1'b1, 1'b0, exp_bit(e.data, k)};
          first_bad = want;
          for (int s = 0; s < e.p; s++) begin
            if (!(k == 0 && s == 0)) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            got = {busy, s_axis_tready, txd};
            if (got !== want) begin
              if (bad == 0) first_bad = got;
              bad++;
            end
          end
          if (!aborted) begin
            n_checks++;
            if (bad == 0) n_pass++;
            else $display("FAIL bit%0d of %02h p=%0d: %0d bad samples, first {busy,tready,txd}=%b expected %b",
                          k, e.data, e.p, bad, first_bad, want);
          end
        end
        @(negedge clk);
        if (aborted) begin
          check("reset_abort", {29'd0, busy, s_axis_tready, txd}, 32'b001);
          idle = 0;
        end else begin
          check($sformatf("frame_end_%02h", e.data), {29'd0, busy, s_axis_tready, txd}, 32'b011);
          idle = 1;
        end
      end
      mon_active = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [15:0] ps, input bit hold);
    int n;
    s_axis_tdata  = d;
    prescale      = ps;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (s_axis_tready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      check("tready_timeout", 32'd0, 32'd1);
      s_axis_tvalid = 1'b0;
      return;
    end
    sb.push_back('{data: d, p: (ps == 16'd0) ? 1 : int'(ps), b2b: b2b_next});
    @(posedge clk);
    #1;
    b2b_next = hold;
    if (!hold) s_axis_tvalid = 1'b0;
  endtask

  // Idle until the frame ends, scrambling tdata/prescale to show they are ignored mid-frame.
  task automatic gap();
    int n;
    s_axis_tvalid = 1'b0;
    b2b_next = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      s_axis_tdata = W'($urandom);
      prescale = 16'($urandom);
      n++;
    end while (s_axis_tready !== 1'b1 && n < 20000);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin : stim
    logic [W-1:0] d;
    logic [15:0]  ps;
    bit           hold;
    int           n;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {29'd0, busy, s_axis_tready, txd}, 32'b001);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("tready_on_last_reset_edge", {31'd0, s_axis_tready}, 32'd0);
    @(negedge clk);
    check("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

    send(8'hA5, 16'd4, 1'b0);
    gap();

    send(8'hFF, 16'd4, 1'b0);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    b2b_next = 1'b0;
    send(8'h3C, 16'd4, 1'b0);
    gap();

    for (int i = 0; i < 8; i++) send(W'(i), 16'd416, i != 7);
    gap();

    send(8'h5A, 16'd4, 1'b1);
    send(8'hC3, 16'd8, 1'b0);
    gap();
    send(8'h81, 16'd0, 1'b1);
    send(8'h7E, 16'd0, 1'b0);
    gap();
    send(8'h01, 16'd3, 1'b0);
    gap();
    send(8'h03, 16'd3, 1'b0);
    gap();

    repeat (40) begin
      d = W'($urandom);
      ps = 16'($urandom_range(0, 12));
      hold = 1'($urandom_range(0, 1));
      send(d, ps, hold);
      if (!hold) gap();
    end
    gap();

    n = 0;
    while ((sb.size() != 0 || mon_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size() + int'(mon_active), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
